cache_controller: RTL

Memory-stage front end that drives the 2-way data cache from the pipeline side and fills it from external SRAM. Serves read hits in the same cycle. Handles read misses by fetching the word from SRAM and writing it into the cache. Stores are write-through with invalidate-on-hit. The `ready` output freezes the pipeline while an SRAM access is outstanding.

---
 rtl/cache_ctrl_pkg.sv | 16 +
 rtl/cache_controller_sat_counter.sv | 23 ++
 rtl/cache_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the data-cache front end.
// Holds the FSM state encoding and the address/data geometry.
package cache_ctrl_pkg;

  localparam logic [31:0] BASE_ADDR = 32'd1024;
  localparam int          ADDR_W    = 18;
  localparam int          DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    FILL    = 2'd2,
    WR_THRU = 2'd3
  } state_t;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/cache_controller.sv
// Pipeline-side controller for the 2-way data cache: same-cycle read hits,
// SRAM fill on read miss, write-through stores that invalidate on hit.
module cache_controller #(
  parameter logic [31:0] BASE_ADDR = cache_ctrl_pkg::BASE_ADDR,
  parameter int          CNT_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mem_rd_en,
  input  logic                              mem_wr_en,
  input  logic [31:0]                       mem_addr,
  input  logic [cache_ctrl_pkg::DATA_W-1:0] mem_wdata,
  output logic [cache_ctrl_pkg::DATA_W-1:0] mem_rdata,
  output logic                              ready,
  output logic [cache_ctrl_pkg::ADDR_W-1:0] cache_address,
  output logic [cache_ctrl_pkg::DATA_W-1:0] cache_data_in,
  output logic                              cache_wr_en,
  output logic                              cache_rd_en,
  output logic                              cache_inv,
  input  logic                              cache_hit,
  input  logic [cache_ctrl_pkg::DATA_W-1:0] cache_data_out,
  output logic [cache_ctrl_pkg::ADDR_W-1:0] sram_addr,
  output logic [cache_ctrl_pkg::DATA_W-1:0] sram_wdata,
  output logic                              sram_rd_en,
  output logic                              sram_wr_en,
  input  logic [cache_ctrl_pkg::DATA_W-1:0] sram_rdata,
  input  logic                              sram_ready,
  output logic [CNT_W-1:0]                  hit_count,
  output logic [CNT_W-1:0]                  miss_count
);

  import cache_ctrl_pkg::*;

  state_t              state_reg;
  logic [DATA_W-1:0]   fill_reg;
  logic [31:0]         offset;
  logic                unused_offset_bits;
  logic                rd_access;
  logic                hit_inc;
  logic                miss_inc;

  // Only the low address bits reach the cache/SRAM; the rest must be zero.
  assign offset             = mem_addr - BASE_ADDR;
  assign cache_address      = offset[ADDR_W-1:0];
  assign sram_addr          = offset[ADDR_W-1:0];
  assign unused_offset_bits = ^offset[31:ADDR_W];

  assign cache_data_in = fill_reg;
  assign sram_wdata    = mem_wdata;

  // A store in the same cycle as a load wins, so the load is not counted.
  assign rd_access = (state_reg == IDLE) && mem_rd_en && !mem_wr_en;
  assign hit_inc   = rd_access && cache_hit;
  assign miss_inc  = rd_access && !cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      fill_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_wr_en) begin
            state_reg <= WR_THRU;
          end else if (mem_rd_en && !cache_hit) begin
            state_reg <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            fill_reg  <= sram_rdata;
            state_reg <= FILL;
          end
        end
        FILL: begin
          state_reg <= IDLE;
        end
        WR_THRU: begin
          if (sram_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ready       = 1'b1;
    mem_rdata   = '0;
    cache_wr_en = 1'b0;
    cache_rd_en = 1'b0;
    cache_inv   = 1'b0;
    sram_rd_en  = 1'b0;
    sram_wr_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_wr_en) begin
          ready     = 1'b0;
          cache_inv = cache_hit;
        end else if (mem_rd_en) begin
          if (cache_hit) begin
            mem_rdata   = cache_data_out;
            cache_rd_en = 1'b1;
          end else begin
            ready = 1'b0;
          end
        end
      end
      RD_MISS: begin
        sram_rd_en = 1'b1;
        ready      = 1'b0;
      end
      FILL: begin
        cache_wr_en = 1'b1;
        mem_rdata   = fill_reg;
      end
      WR_THRU: begin
        sram_wr_en = 1'b1;
        ready      = sram_ready;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule
